// File: rtl/tiled_matmul_pkg.sv
// Shared types and row-major index helpers for the tiled matrix multiplier.
package tiled_matmul_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Flat index of element (r,c) in a row-major n x n matrix.
    function automatic int unsigned elem_idx(input int unsigned r,
                                             input int unsigned c,
                                             input int unsigned n);
        return r * n + c;
    endfunction

    // Flat index of element k (row-major within the tile) of 2x2 tile (ti,tj).
    function automatic int unsigned tile_elem(input int unsigned n,
                                              input int unsigned ti,
                                              input int unsigned tj,
                                              input int unsigned k);
        return elem_idx(2 * ti + k / 2, 2 * tj + k % 2, n);
    endfunction

endpackage

// File: rtl/tiled_matmul_mac.sv
// Combinational 2x2 tile multiply-accumulate: sum_c = acc + a_tile * b_tile.
module mat2x2_mac
    import tiled_matmul_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ACC_WIDTH = 34,
    parameter bit          SIGNED    = 1'b0
) (
    input  logic [4*WIDTH-1:0]     a_tile,
    input  logic [4*WIDTH-1:0]     b_tile,
    input  logic [4*ACC_WIDTH-1:0] acc,
    output logic [4*ACC_WIDTH-1:0] sum_c
);

    localparam int unsigned PW = 2 * WIDTH;

    // Extending operands to the product width makes a plain PW-bit multiply exact.
    function automatic logic [PW-1:0] ext_op(input logic [WIDTH-1:0] x);
        if (SIGNED) return {{WIDTH{x[WIDTH-1]}}, x};
        return {{WIDTH{1'b0}}, x};
    endfunction

    function automatic logic [ACC_WIDTH-1:0] ext_prod(input logic [PW-1:0] p);
        if (SIGNED) return {{(ACC_WIDTH - PW){p[PW-1]}}, p};
        return {{(ACC_WIDTH - PW){1'b0}}, p};
    endfunction

    for (genvar r = 0; r < 2; r++) begin : g_row
        for (genvar c = 0; c < 2; c++) begin : g_col
            localparam int unsigned E   = elem_idx(r, c, 2);
            localparam int unsigned AI0 = elem_idx(r, 0, 2);
            localparam int unsigned AI1 = elem_idx(r, 1, 2);
            localparam int unsigned BI0 = elem_idx(0, c, 2);
            localparam int unsigned BI1 = elem_idx(1, c, 2);

            logic [PW-1:0] p0;
            logic [PW-1:0] p1;

            assign p0 = ext_op(a_tile[AI0*WIDTH +: WIDTH]) * ext_op(b_tile[BI0*WIDTH +: WIDTH]);
            assign p1 = ext_op(a_tile[AI1*WIDTH +: WIDTH]) * ext_op(b_tile[BI1*WIDTH +: WIDTH]);

            assign sum_c[E*ACC_WIDTH +: ACC_WIDTH] = acc[E*ACC_WIDTH +: ACC_WIDTH]
                                                   + ext_prod(p0) + ext_prod(p1);
        end
    end

endmodule

// File: rtl/tiled_matmul.sv
// N x N matrix multiplier computing C = A*B one 2x2 tile MAC per clock.
module tiled_matmul
    import tiled_matmul_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned N         = 4,
    parameter bit          SIGNED    = 1'b0,
    parameter int unsigned ACC_WIDTH = 2 * WIDTH + $clog2(N)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [N*N*WIDTH-1:0]       A,
    input  logic [N*N*WIDTH-1:0]       B,
    output logic [N*N*ACC_WIDTH-1:0]   C,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned T  = N / 2;
    localparam int unsigned CW = (T > 1) ? $clog2(T) : 1;
    localparam int unsigned MW = N * N * WIDTH;
    localparam int unsigned TW = 4 * WIDTH;
    localparam int unsigned TA = 4 * ACC_WIDTH;

    state_t          state_q;
    state_t          state_d;
    logic [CW-1:0]   ti;
    logic [CW-1:0]   tj;
    logic [CW-1:0]   tk;
    logic [MW-1:0]   a_q;
    logic [MW-1:0]   b_q;
    logic [TA-1:0]   acc_q;
    logic [TW-1:0]   a_tile_c;
    logic [TW-1:0]   b_tile_c;
    logic [TA-1:0]   sum_c;
    logic            tk_last_c;
    logic            tj_last_c;
    logic            ti_last_c;
    logic            final_c;

    assign tk_last_c = (tk == CW'(T - 1));
    assign tj_last_c = (tj == CW'(T - 1));
    assign ti_last_c = (ti == CW'(T - 1));
    assign final_c   = tk_last_c && tj_last_c && ti_last_c;

    // Operand tile selection: A tile (ti,tk) and B tile (tk,tj).
    always_comb begin
        a_tile_c = '0;
        b_tile_c = '0;
        for (int k = 0; k < 4; k++) begin
            a_tile_c[k*WIDTH +: WIDTH] = a_q[tile_elem(N, 32'(ti), 32'(tk), k)*WIDTH +: WIDTH];
            b_tile_c[k*WIDTH +: WIDTH] = b_q[tile_elem(N, 32'(tk), 32'(tj), k)*WIDTH +: WIDTH];
        end
    end

    mat2x2_mac #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH),
        .SIGNED    (SIGNED)
    ) u_mac (
        .a_tile (a_tile_c),
        .b_tile (b_tile_c),
        .acc    (acc_q),
        .sum_c  (sum_c)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (final_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ti      <= '0;
            tj      <= '0;
            tk      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            C       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q   <= A;
                        b_q   <= B;
                        ti    <= '0;
                        tj    <= '0;
                        tk    <= '0;
                        acc_q <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (tk_last_c) begin
                        // Tile (ti,tj) is complete: write it back and restart accumulation.
                        for (int k = 0; k < 4; k++) begin
                            C[tile_elem(N, 32'(ti), 32'(tj), k)*ACC_WIDTH +: ACC_WIDTH]
                                <= sum_c[k*ACC_WIDTH +: ACC_WIDTH];
                        end
                        acc_q <= '0;
                        tk    <= '0;
                        if (tj_last_c) begin
                            tj <= '0;
                            ti <= ti_last_c ? '0 : ti + CW'(1);
                        end else begin
                            tj <= tj + CW'(1);
                        end
                    end else begin
                        acc_q <= sum_c;
                        tk    <= tk + CW'(1);
                    end
                    if (final_c) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tiled_matmul.sv
// Directed and random scoreboard bench for tiled_matmul across N=2/4/6, signed and unsigned.
module tb_tiled_matmul;

    localparam int W   = 16;
    localparam int N0  = 4;
    localparam int AC0 = 34;
    localparam int N1  = 4;
    localparam int AC1 = 34;
    localparam int N2  = 2;
    localparam int AC2 = 33;
    localparam int N3  = 6;
    localparam int AC3 = 35;

    typedef logic [2047:0] vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] start_v;
    wire  [3:0] busy_v;
    wire  [3:0] done_v;

    logic [N0*N0*W-1:0] a0, b0;
    logic [N1*N1*W-1:0] a1, b1;
    logic [N2*N2*W-1:0] a2, b2;
    logic [N3*N3*W-1:0] a3, b3;
    wire  [N0*N0*AC0-1:0] c0;
    wire  [N1*N1*AC1-1:0] c1;
    wire  [N2*N2*AC2-1:0] c2;
    wire  [N3*N3*AC3-1:0] c3;

    int   checks   = 0;
    int   failures = 0;
    vec_t exp_q[$];

    always #5 clk = ~clk;

    tiled_matmul #(.WIDTH(W), .N(N0), .SIGNED(1'b0)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .A(a0), .B(b0), .C(c0),
        .busy(busy_v[0]), .done(done_v[0]));
    tiled_matmul #(.WIDTH(W), .N(N1), .SIGNED(1'b1)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .A(a1), .B(b1), .C(c1),
        .busy(busy_v[1]), .done(done_v[1]));
    tiled_matmul #(.WIDTH(W), .N(N2), .SIGNED(1'b0)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .A(a2), .B(b2), .C(c2),
        .busy(busy_v[2]), .done(done_v[2]));
    tiled_matmul #(.WIDTH(W), .N(N3), .SIGNED(1'b1)) u3 (
        .clk(clk), .rst(rst), .start(start_v[3]), .A(a3), .B(b3), .C(c3),
        .busy(busy_v[3]), .done(done_v[3]));

    function automatic int n_of(input int id);
        case (id)
            0: return N0;
            1: return N1;
            2: return N2;
            default: return N3;
        endcase
    endfunction

    function automatic int acc_of(input int id);
        case (id)
            0: return AC0;
            1: return AC1;
            2: return AC2;
            default: return AC3;
        endcase
    endfunction

    function automatic bit sgn_of(input int id);
        return (id == 1) || (id == 3);
    endfunction

    function automatic vec_t get_c(input int id);
        case (id)
            0: return vec_t'(c0);
            1: return vec_t'(c1);
            2: return vec_t'(c2);
            default: return vec_t'(c3);
        endcase
    endfunction

    function automatic logic [63:0] elem(input vec_t v, input int e, input int acc);
        logic [63:0] r = '0;
        for (int bt = 0; bt < acc; bt++) r[bt] = v[e*acc + bt];
        return r;
    endfunction

    function automatic longint sx(input logic [W-1:0] v, input bit s);
        if (s) return longint'($signed(v));
        return longint'({48'h0, v});
    endfunction

    // Plain row-by-column dot products, truncated to the result element width.
    function automatic vec_t ref_model(input int id, input vec_t a, input vec_t b);
        int n = n_of(id);
        int acc = acc_of(id);
        bit s = sgn_of(id);
        vec_t r = '0;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                longint sum = 0;
                logic [63:0] sv;
                for (int k = 0; k < n; k++)
                    sum += sx(a[(i*n+k)*W +: W], s) * sx(b[(k*n+j)*W +: W], s);
                sv = sum;
                for (int bt = 0; bt < acc; bt++) r[(i*n+j)*acc + bt] = sv[bt];
            end
        end
        return r;
    endfunction

    function automatic vec_t rand_ops(input int id);
        vec_t v = '0;
        int n = n_of(id);
        for (int e = 0; e < n*n; e++) v[e*W +: W] = 16'($urandom);
        return v;
    endfunction

    task automatic set_ops(input int id, input vec_t a, input vec_t b);
        case (id)
            0: begin a0 = a[N0*N0*W-1:0]; b0 = b[N0*N0*W-1:0]; end
            1: begin a1 = a[N1*N1*W-1:0]; b1 = b[N1*N1*W-1:0]; end
            2: begin a2 = a[N2*N2*W-1:0]; b2 = b[N2*N2*W-1:0]; end
            default: begin a3 = a[N3*N3*W-1:0]; b3 = b[N3*N3*W-1:0]; end
        endcase
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expected result and compare it element by element.
    task automatic check_result(input int id, input string tag);
        vec_t e;
        vec_t g;
        int n = n_of(id);
        int acc = acc_of(id);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'(exp_q.size()), 64'd1);
            return;
        end
        e = exp_q.pop_front();
        g = get_c(id);
        for (int el = 0; el < n*n; el++)
            chk($sformatf("%s_c%0d", tag, el), elem(g, el, acc), elem(e, el, acc));
    endtask

    // Drive start for one edge with the given operands, then scramble operands.
    task automatic launch(input int id, input vec_t a, input vec_t b);
        set_ops(id, a, b);
        start_v[id] = 1'b1;
        exp_q.push_back(ref_model(id, a, b));
        @(negedge clk);
        start_v[id] = 1'b0;
        set_ops(id, rand_ops(id), rand_ops(id));
    endtask

    task automatic wait_done(input int id, input int lat_in, output int lat, output int busy_n);
        lat = lat_in;
        busy_n = 0;
        while (!done_v[id] && lat < 64) begin
            if (busy_v[id]) busy_n++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic b2b(input int id, input string tag, input int exp_lat, input int runs);
        int lat;
        int bn;
        launch(id, rand_ops(id), rand_ops(id));
        for (int r = 0; r < runs; r++) begin
            wait_done(id, 0, lat, bn);
            chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
            check_result(id, tag);
            if (r < runs - 1) launch(id, rand_ops(id), rand_ops(id));
        end
        @(negedge clk);
    endtask

    initial begin
        vec_t a;
        vec_t b;
        int lat;
        int bn;

        start_v = '0;
        set_ops(0, '0, '0);
        set_ops(1, '0, '0);
        set_ops(2, '0, '0);
        set_ops(3, '0, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        chk("rst_busy", 64'(busy_v), 64'd0);
        chk("rst_done", 64'(done_v), 64'd0);
        chk("rst_c_nonzero", 64'((get_c(0) | get_c(1) | get_c(2) | get_c(3)) != '0), 64'd0);

        // Identity times an index matrix returns the index matrix.
        a = '0;
        b = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a[(r*4+c)*W +: W] = (r == c) ? 16'd1 : 16'd0;
                b[(r*4+c)*W +: W] = 16'(r*4 + c);
            end
        launch(0, a, b);
        wait_done(0, 0, lat, bn);
        chk("ident_lat", 64'(lat), 64'd8);
        chk("ident_busy_cycles", 64'(bn), 64'd8);
        chk("ident_c6", elem(get_c(0), 6, AC0), 64'd6);
        check_result(0, "ident");
        @(negedge clk);
        chk("ident_done_once", 64'(done_v[0]), 64'd0);
        chk("ident_busy_after", 64'(busy_v[0]), 64'd0);

        // Full-scale unsigned operands must not truncate.
        a = '0;
        for (int e = 0; e < 16; e++) a[e*W +: W] = 16'hFFFF;
        launch(0, a, a);
        wait_done(0, 0, lat, bn);
        chk("max_lat", 64'(lat), 64'd8);
        chk("max_c0", elem(get_c(0), 0, AC0), 64'd17179344900);
        check_result(0, "max");

        // Signed: -1 * 2 summed over 4 gives -8 in 34 bits.
        b = '0;
        for (int e = 0; e < 16; e++) b[e*W +: W] = 16'd2;
        launch(1, a, b);
        wait_done(1, 0, lat, bn);
        chk("neg_lat", 64'(lat), 64'd8);
        chk("neg_c5", elem(get_c(1), 5, AC1), 64'h3_FFFF_FFF8);
        check_result(1, "neg");

        // Starts during a run are ignored; a start in the done cycle is accepted.
        launch(0, rand_ops(0), rand_ops(0));
        @(negedge clk);
        @(negedge clk);
        set_ops(0, rand_ops(0), rand_ops(0));
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        set_ops(0, rand_ops(0), rand_ops(0));
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        wait_done(0, 6, lat, bn);
        chk("proto1_lat", 64'(lat), 64'd8);
        check_result(0, "proto1");
        launch(0, rand_ops(0), rand_ops(0));
        wait_done(0, 0, lat, bn);
        chk("proto2_lat", 64'(lat), 64'd8);
        check_result(0, "proto2");
        @(negedge clk);

        // Asynchronous reset in RUN cycle 4 clears everything immediately.
        launch(0, rand_ops(0), rand_ops(0));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 64'(busy_v[0]), 64'd0);
        chk("midrst_done", 64'(done_v[0]), 64'd0);
        chk("midrst_c_nonzero", 64'(get_c(0) != '0), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        void'(exp_q.pop_front());
        @(negedge clk);
        chk("midrst_no_done", 64'(done_v[0]), 64'd0);
        launch(0, rand_ops(0), rand_ops(0));
        wait_done(0, 0, lat, bn);
        chk("postrst_lat", 64'(lat), 64'd8);
        check_result(0, "postrst");
        @(negedge clk);

        b2b(2, "n2", 1, 200);
        b2b(3, "n6", 27, 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tiled_matmul.md
# tiled_matmul

Parametrised N×N matrix multiplier for the systolic/MLAI compute path. It computes C = A·B sequentially over 2×2 tiles: one tile multiply-accumulate per clock, with a start/busy/done handshake. This generation supports any even N, signed or unsigned operands, and full-precision accumulation with no truncation. It replaces the fixed 4×4, single-shot tile multiplier.

## Interface
- `WIDTH`, 16, operand element width in bits.
- `N`, 4, matrix dimension; must be even and ≥2.
- `SIGNED`, 0, 0 = unsigned operands, 1 = two's-complement operands.
- `ACC_WIDTH`, 2*WIDTH+$clog2(N), result element width.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request; sampled only in IDLE.
- `A`  in  N*N*WIDTH  flattened row-major; element (r,c) = `A[(r*N+c)*WIDTH +: WIDTH]`.
- `B`  in  N*N*WIDTH  same layout as `A`.
- `C`  out  N*N*ACC_WIDTH  row-major; element (r,c) = `C[(r*N+c)*ACC_WIDTH +: ACC_WIDTH]`.
- `busy`  out  1  high while a multiply is in progress.
- `done`  out  1  one-cycle pulse when `C` is complete.

## Operation
- T = N/2 tiles per dimension. Counters `ti`, `tj`, `tk` each range 0..T-1, with `tk` innermost and `tj` middle.
- States:
  - IDLE: `start`=1 latches `A` and `B` into internal registers, clears counters and the tile accumulator, and moves to RUN.
  - RUN: each cycle adds tile(A,ti,tk)·tile(B,tk,tj) to the 4-element tile accumulator.
    - When `tk`=T-1, the sum (accumulator + current product) is written to C tile (ti,tj) and the accumulator clears.
    - On the final step (ti=tj=tk=T-1), the block sets `done`<=1 and returns to IDLE.
- Arithmetic:
  - Products are full 2*WIDTH.
  - Operands are sign-extended when SIGNED=1, zero-extended otherwise.
  - Accumulation is at ACC_WIDTH, so no overflow is possible.
- Operands are latched, so `A`/`B` may change freely after the start cycle.
- `start` while busy is ignored (no queueing). `start` in the `done` cycle is accepted, because the state is already IDLE.
- `C` retains the previous result between runs and is overwritten tile by tile during RUN. `C` is valid only from the `done` pulse until the next accepted `start`.
- Reset values: `C`=0, `busy`=0, `done`=0, state IDLE, counters and accumulator 0.
- Reset mid-run aborts immediately. No `done` is produced, and `C` is forced to 0.

## Timing
- Edge e0 accepts `start`. RUN occupies T³ cycles, at edges e1..e(T³).
- `busy` is high from after e0 until e(T³). `done` is high for exactly one cycle, after edge e(T³), i.e. T³ cycles after acceptance.
- Example N=4: done appears 8 cycles after start. N=2: 1 cycle.
- Back-to-back throughput: one result per T³+1 cycles.
- The tile product and add form a single-cycle combinational path: 2 multipliers plus a 3-input adder per element, 4 elements.

## Structure
- Package `tiled_matmul_pkg`:
  - state enum `{IDLE, RUN}`;
  - functions `elem_idx(r,c,n)` and `tile_elem(mat,ti,tj,k)` for row-major slicing.
- Sub-module `mat2x2_mac`: combinational. Takes 2×2 A and B tiles (WIDTH) plus a 2×2 accumulator (ACC_WIDTH) and returns acc + A·B. It is parametrised by WIDTH, ACC_WIDTH and SIGNED.
- Top level: FSM, counters, operand registers, tile write-back into `C`.

## Test plan
- N=4 unsigned, A=identity, B[r][c]=r*4+c:
  - `C` must equal `B`;
  - `busy` high for 8 cycles;
  - `done` pulses once, 8 cycles after start.
- N=4 unsigned, all elements of A and B =65535: every C element is 17179344900. This fits the 34-bit ACC_WIDTH; check there is no truncation.
- N=4 SIGNED=1, A all −1, B all 2: every C element is −8 (34-bit two's complement).
- Protocol check: assert `start` at cycles 2 and 5 of a run; both are ignored. Assert `start` again in the `done` cycle; a second run starts immediately, and its result matches a new A/B pair that was changed after the first start.
- Pulse `rst` at RUN cycle 4: `busy`/`done`/`C` all return to 0 asynchronously. A following start produces a correct result.
- N=2 and N=6 with random operands: results match a reference model, latency is 1 and 27 cycles respectively, and 200 back-to-back runs produce no mismatches.
